// File: rtl/store_buffer_pkg.sv
// Shared defaults and the buffered store entry layout for the store buffer.
package store_buffer_pkg;

  localparam int unsigned SB_DEPTH = 4;
  localparam int unsigned SB_AW    = 32;
  localparam int unsigned SB_DW    = 32;

  typedef struct packed {
    logic [SB_AW-1:0] addr;
    logic [SB_DW-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/sb_fwd_match.sv
// Store-to-load forwarding lookup: word-address match against all valid
// entries, newest (closest to tail) match wins.
module sb_fwd_match
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = SB_DEPTH,
  parameter int unsigned AW    = SB_AW,
  parameter int unsigned DW    = SB_DW,
  localparam int unsigned PW   = $clog2(DEPTH)
) (
  input  logic [AW-1:0]    entry_addr [DEPTH],
  input  logic [DW-1:0]    entry_data [DEPTH],
  input  logic [DEPTH-1:0] valid,
  input  logic [PW-1:0]    tail,
  input  logic [AW-1:0]    rd_adr,
  output logic             hit,
  output logic [DW-1:0]    data
);

  localparam logic [AW-1:0] WORD_MASK = ~(AW'(3));

  // Walk from the slot at tail (oldest when full) toward tail-1 (newest),
  // so a later match overwrites an earlier one.
  always_comb begin
    logic [PW-1:0] idx;
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = tail + PW'(k);
      if (valid[idx] && (((entry_addr[idx] ^ rd_adr) & WORD_MASK) == '0)) begin
        hit  = 1'b1;
        data = entry_data[idx];
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Circular FIFO of pending stores draining to data memory, with
// combinational store-to-load forwarding and a sticky overflow flag.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = SB_DEPTH,
  parameter int unsigned AW    = SB_AW,
  parameter int unsigned DW    = SB_DW
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   memwrite,
  input  logic [AW-1:0]          dataadr,
  input  logic [DW-1:0]          writedata,
  input  logic [AW-1:0]          rd_adr,
  output logic                   fwd_hit,
  output logic [DW-1:0]          fwd_data,
  output logic                   m_valid,
  output logic [AW-1:0]          m_addr,
  output logic [DW-1:0]          m_wdata,
  input  logic                   m_ready,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [AW-1:0]    addr_q [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PW-1:0]    head_q;
  logic [PW-1:0]    tail_q;
  logic [CW-1:0]    count_q;
  logic             overflow_q;
  logic             do_enq;
  logic             do_deq;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign count    = count_q;
  assign overflow = overflow_q;
  assign m_valid  = !empty;
  assign m_addr   = addr_q[head_q];
  assign m_wdata  = data_q[head_q];

  assign do_deq = m_valid & m_ready;
  assign do_enq = memwrite & (!full | do_deq);

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      valid_q    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      // When full, head and tail share a slot: the clear comes first so a
      // simultaneous enqueue leaves that slot valid.
      if (do_deq) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PW'(1);
      end
      if (do_enq) begin
        addr_q[tail_q]  <= dataadr;
        data_q[tail_q]  <= writedata;
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + PW'(1);
      end
      case ({do_enq, do_deq})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (memwrite && full && !do_deq) overflow_q <= 1'b1;
    end
  end

  sb_fwd_match #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_fwd_match (
    .entry_addr (addr_q),
    .entry_data (data_q),
    .valid      (valid_q),
    .tail       (tail_q),
    .rd_adr     (rd_adr),
    .hit        (fwd_hit),
    .data       (fwd_data)
  );

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer at default parameters.
module tb_store_buffer;
  import store_buffer_pkg::*;

  logic        clk;
  logic        reset;
  logic        memwrite;
  logic [31:0] dataadr;
  logic [31:0] writedata;
  logic [31:0] rd_adr;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic        m_valid;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_ready;
  logic        full;
  logic        empty;
  logic [2:0]  count;
  logic        overflow;

  int total = 0;
  int bad   = 0;

  store_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .memwrite  (memwrite),
    .dataadr   (dataadr),
    .writedata (writedata),
    .rd_adr    (rd_adr),
    .fwd_hit   (fwd_hit),
    .fwd_data  (fwd_data),
    .m_valid   (m_valid),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_ready   (m_ready),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; memwrite = 1'b1; dataadr = 32'h44; writedata = 32'h77; m_ready = 1'b1;
    step();
    step();
    reset = 1'b0; memwrite = 1'b0; m_ready = 1'b0; rd_adr = 32'h44;
    #1;
    total++;
    if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++;
    if ({m_valid, empty, full, overflow} !== 4'b0100) begin
      bad++; $display("FAIL reset_flags got v/e/f/o=%b exp=0100", {m_valid, empty, full, overflow});
    end
    total++;
    if (m_addr !== 32'h0 || m_wdata !== 32'h0) begin
      bad++; $display("FAIL reset_head got addr=%h data=%h exp=0/0", m_addr, m_wdata);
    end
    total++;
    if (fwd_hit !== 1'b0 || fwd_data !== 32'h0) begin
      bad++; $display("FAIL reset_fwd got hit=%b data=%h exp=0/0", fwd_hit, fwd_data);
    end
  endtask

  task automatic test_single();
    memwrite = 1'b1; dataadr = 32'h10; writedata = 32'hAAAA0001; m_ready = 1'b0; rd_adr = 32'h10;
    #1;
    total++;
    if (fwd_hit !== 1'b0 || m_valid !== 1'b0) begin
      bad++; $display("FAIL same_cycle_invisible got hit=%b valid=%b exp=0/0", fwd_hit, m_valid);
    end
    step();
    memwrite = 1'b0;
    #1;
    total++;
    if (m_valid !== 1'b1 || m_addr !== 32'h10 || m_wdata !== 32'hAAAA0001 || count !== 3'd1) begin
      bad++; $display("FAIL single_store got v=%b addr=%h data=%h cnt=%0d exp=1/10/aaaa0001/1",
                      m_valid, m_addr, m_wdata, count);
    end
    total++;
    if (fwd_hit !== 1'b1 || fwd_data !== 32'hAAAA0001) begin
      bad++; $display("FAIL single_fwd got hit=%b data=%h exp=1/aaaa0001", fwd_hit, fwd_data);
    end
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    #1;
    total++;
    if (empty !== 1'b1 || count !== 3'd0 || fwd_hit !== 1'b0) begin
      bad++; $display("FAIL single_drain got e=%b cnt=%0d hit=%b exp=1/0/0", empty, count, fwd_hit);
    end
  endtask

  task automatic test_fwd_newest();
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      memwrite = 1'b1; dataadr = 32'h20; writedata = 32'(i + 1); m_ready = 1'b0;
      step();
    end
    memwrite = 1'b0; rd_adr = 32'h20;
    #1;
    total++;
    if (full !== 1'b1 || count !== 3'd4 || m_wdata !== 32'd1) begin
      bad++; $display("FAIL fill_four got f=%b cnt=%0d head=%h exp=1/4/1", full, count, m_wdata);
    end
    total++;
    if (fwd_hit !== 1'b1 || fwd_data !== 32'd4) begin
      bad++; $display("FAIL fwd_newest got hit=%b data=%h exp=1/4", fwd_hit, fwd_data);
    end
    rd_adr = 32'h22;
    #1;
    total++;
    if (fwd_hit !== 1'b1 || fwd_data !== 32'd4) begin
      bad++; $display("FAIL fwd_low_bits got hit=%b data=%h exp=1/4", fwd_hit, fwd_data);
    end
    rd_adr = 32'h24;
    #1;
    total++;
    if (fwd_hit !== 1'b0 || fwd_data !== 32'h0) begin
      bad++; $display("FAIL fwd_miss got hit=%b data=%h exp=0/0", fwd_hit, fwd_data);
    end
  endtask

  task automatic test_overflow();
    memwrite = 1'b1; dataadr = 32'h30; writedata = 32'h5; m_ready = 1'b0;
    step();
    memwrite = 1'b0; rd_adr = 32'h30;
    #1;
    total++;
    if (overflow !== 1'b1 || count !== 3'd4 || fwd_hit !== 1'b0) begin
      bad++; $display("FAIL overflow_drop got o=%b cnt=%0d hit=%b exp=1/4/0", overflow, count, fwd_hit);
    end
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if (m_valid !== 1'b1 || m_wdata !== 32'(i + 1)) begin
        bad++; $display("FAIL overflow_drain_%0d got v=%b data=%h exp=1/%h", i, m_valid, m_wdata, i + 1);
      end
      step();
    end
    m_ready = 1'b0;
    #1;
    total++;
    if (empty !== 1'b1 || overflow !== 1'b1) begin
      bad++; $display("FAIL overflow_sticky got e=%b o=%b exp=1/1", empty, overflow);
    end
  endtask

  task automatic test_full_simul();
    logic [31:0] exp_data [4];
    exp_data = '{32'h101, 32'h102, 32'h103, 32'h999};
    pulse_reset();
    total++;
    if (overflow !== 1'b0) begin bad++; $display("FAIL overflow_cleared got=%b exp=0", overflow); end
    for (int i = 0; i < 4; i++) begin
      memwrite = 1'b1; dataadr = 32'h40 + 32'(4 * i); writedata = 32'h100 + 32'(i); m_ready = 1'b0;
      step();
    end
    memwrite = 1'b1; dataadr = 32'h80; writedata = 32'h999; m_ready = 1'b1;
    step();
    memwrite = 1'b0; m_ready = 1'b0; rd_adr = 32'h80;
    #1;
    total++;
    if (count !== 3'd4 || overflow !== 1'b0 || full !== 1'b1 || m_wdata !== 32'h101) begin
      bad++; $display("FAIL full_simul got cnt=%0d o=%b f=%b head=%h exp=4/0/1/101",
                      count, overflow, full, m_wdata);
    end
    total++;
    if (fwd_hit !== 1'b1 || fwd_data !== 32'h999) begin
      bad++; $display("FAIL full_simul_fwd got hit=%b data=%h exp=1/999", fwd_hit, fwd_data);
    end
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if (m_valid !== 1'b1 || m_wdata !== exp_data[i]) begin
        bad++; $display("FAIL full_simul_drain_%0d got v=%b data=%h exp=1/%h", i, m_valid, m_wdata, exp_data[i]);
      end
      step();
    end
    m_ready = 1'b0;
  endtask

  task automatic test_wrap();
    sb_entry_t   q[$];
    int          sent;
    logic        prev_stall;
    logic [31:0] held_addr;
    logic        deq;
    logic        enq;
    sent = 0; prev_stall = 1'b0; held_addr = '0;
    pulse_reset();
    for (int c = 0; c < 40 && (sent < 10 || q.size() != 0); c++) begin
      memwrite  = (sent < 10);
      dataadr   = 32'h1000 + 32'(4 * sent);
      writedata = 32'h500 + 32'(sent);
      m_ready   = (c % 3 != 0);
      #1;
      total++;
      if (m_valid !== (q.size() != 0) || count !== 3'(q.size())) begin
        bad++; $display("FAIL wrap_occupancy_c%0d got v=%b cnt=%0d exp_cnt=%0d", c, m_valid, count, q.size());
      end
      if (q.size() != 0) begin
        total++;
        if (m_addr !== q[0].addr || m_wdata !== q[0].data) begin
          bad++; $display("FAIL wrap_order_c%0d got %h/%h exp %h/%h", c, m_addr, m_wdata, q[0].addr, q[0].data);
        end
      end
      if (prev_stall) begin
        total++;
        if (m_addr !== held_addr) begin
          bad++; $display("FAIL wrap_stable_c%0d got %h exp %h", c, m_addr, held_addr);
        end
      end
      deq = m_ready && (q.size() != 0);
      enq = memwrite && (q.size() < 4 || deq);
      prev_stall = (q.size() != 0) && !m_ready;
      held_addr  = m_addr;
      if (deq) void'(q.pop_front());
      if (enq) begin
        q.push_back('{addr: dataadr, data: writedata});
        sent++;
      end
      step();
    end
    memwrite = 1'b0; m_ready = 1'b0;
    #1;
    total++;
    if (q.size() != 0 || sent != 10 || empty !== 1'b1) begin
      bad++; $display("FAIL wrap_complete got sent=%0d left=%0d e=%b exp=10/0/1", sent, q.size(), empty);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] probes [4];
    probes = '{32'h60, 32'h64, 32'h68, 32'h70};
    for (int i = 0; i < 3; i++) begin
      memwrite = 1'b1; dataadr = 32'h60 + 32'(4 * i); writedata = 32'h60 + 32'(i); m_ready = 1'b0;
      step();
    end
    reset = 1'b1; memwrite = 1'b1; dataadr = 32'h70; writedata = 32'h70; m_ready = 1'b1;
    step();
    reset = 1'b0; memwrite = 1'b0; m_ready = 1'b0;
    #1;
    total++;
    if (count !== 3'd0 || m_valid !== 1'b0 || empty !== 1'b1 || overflow !== 1'b0) begin
      bad++; $display("FAIL reset_mid got cnt=%0d v=%b e=%b o=%b exp=0/0/1/0", count, m_valid, empty, overflow);
    end
    for (int i = 0; i < 4; i++) begin
      rd_adr = probes[i];
      #1;
      total++;
      if (fwd_hit !== 1'b0) begin
        bad++; $display("FAIL reset_mid_fwd_%h got hit=%b exp=0", probes[i], fwd_hit);
      end
    end
  endtask

  initial begin
    reset = 1'b1; memwrite = 1'b0; dataadr = '0; writedata = '0; rd_adr = '0; m_ready = 1'b0;
    test_reset();
    test_single();
    test_fwd_newest();
    test_overflow();
    test_full_simul();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
